// File: rtl/fifo_drain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_ctrl_if
// Description : Bundle of the FIFO-side status/data signals and the
//               DAC-side sample outputs used by fifo_drain_ctrl.
//               master : the drain controller (drives fifo_rd and the
//                        sample/status outputs)
//               slave  : the environment (drives enable, tick and the
//                        FIFO status flags and read data)
// Ports       : enable, sample_tick, fifo_empty, fifo_threshold, fifo_data
//               (into the controller); fifo_rd, sample_out, sample_valid,
//               underrun_cnt, tick_overrun, running (out of the controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_drain_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  enable;
  logic                  sample_tick;
  logic                  fifo_empty;
  logic                  fifo_threshold;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] sample_out;
  logic                  sample_valid;
  logic [CNT_WIDTH-1:0]  underrun_cnt;
  logic                  tick_overrun;
  logic                  running;

  modport master (
    input  enable, sample_tick, fifo_empty, fifo_threshold, fifo_data,
    output fifo_rd, sample_out, sample_valid, underrun_cnt, tick_overrun, running
  );

  modport slave (
    output enable, sample_tick, fifo_empty, fifo_threshold, fifo_data,
    input  fifo_rd, sample_out, sample_valid, underrun_cnt, tick_overrun, running
  );
endinterface
`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_ctrl
// Description : Read-side consumer of the 16-deep audio sample FIFO. Waits
//               for the FIFO to pre-fill to threshold, then pops one sample
//               per sample-rate tick and presents it to the DAC. An empty
//               FIFO at tick time produces a muted (or repeated) sample,
//               bumps a saturating underrun counter and returns to pre-fill.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous active-low reset
//               bus (master) - enable, sample_tick, fifo_empty,
//                              fifo_threshold, fifo_data in;
//                              fifo_rd, sample_out, sample_valid,
//                              underrun_cnt, tick_overrun, running out
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH       = 16,
  parameter int CNT_WIDTH        = 16,
  parameter bit MUTE_ON_UNDERRUN = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  fifo_drain_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_RUN     = 3'd2,
    ST_READ    = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic                  r_fifo_rd;
  logic [DATA_WIDTH-1:0] r_sample_out;
  logic                  r_sample_valid;
  logic [CNT_WIDTH-1:0]  r_underrun_cnt;
  logic                  r_tick_overrun;
  logic                  r_running;

  // Every output comes straight from a flop; running is updated alongside
  // each state transition so that it tracks RUN/READ/CAPTURE exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_fifo_rd      <= 1'b0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_underrun_cnt <= '0;
      r_tick_overrun <= 1'b0;
      r_running      <= 1'b0;
    end else begin
      // Read request and valid strobe are single-cycle pulses.
      r_fifo_rd      <= 1'b0;
      r_sample_valid <= 1'b0;

      if (!bus.enable) begin
        // Disable wins over everything: any fetch in flight is dropped and
        // sample_out keeps its last value. The underrun count survives.
        r_state        <= ST_IDLE;
        r_running      <= 1'b0;
        r_tick_overrun <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state        <= ST_PREFILL;
            r_tick_overrun <= 1'b0;
          end

          ST_PREFILL: begin
            // Keep the DAC fed with silence while the FIFO fills; these are
            // expected gaps, not underruns.
            if (bus.sample_tick) begin
              r_sample_out   <= '0;
              r_sample_valid <= 1'b1;
            end
            if (bus.fifo_threshold) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end

          ST_RUN: begin
            if (bus.sample_tick) begin
              if (!bus.fifo_empty) begin
                r_fifo_rd <= 1'b1;
                r_state   <= ST_READ;
              end else begin
                if (MUTE_ON_UNDERRUN) begin
                  r_sample_out <= '0;
                end
                r_sample_valid <= 1'b1;
                if (r_underrun_cnt != C_CNT_MAX) begin
                  r_underrun_cnt <= r_underrun_cnt + C_CNT_ONE;
                end
                r_state   <= ST_PREFILL;
                r_running <= 1'b0;
              end
            end
          end

          ST_READ: begin
            // FIFO data shows up during the following cycle.
            if (bus.sample_tick) begin
              r_tick_overrun <= 1'b1;
            end
            r_state <= ST_CAPTURE;
          end

          ST_CAPTURE: begin
            if (bus.sample_tick) begin
              r_tick_overrun <= 1'b1;
            end
            r_sample_out   <= bus.fifo_data;
            r_sample_valid <= 1'b1;
            r_state        <= ST_RUN;
          end

          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.fifo_rd      = r_fifo_rd;
  assign bus.sample_out   = r_sample_out;
  assign bus.sample_valid = r_sample_valid;
  assign bus.underrun_cnt = r_underrun_cnt;
  assign bus.tick_overrun = r_tick_overrun;
  assign bus.running      = r_running;

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain_ctrl
// Description : Self-checking bench for fifo_drain_ctrl. Two instances share
//               one stimulus stream: dut0 with default parameters and dut1
//               with MUTE_ON_UNDERRUN=0 and a 2-bit underrun counter.
//               A timeline-based reference model predicts every output of
//               both instances each cycle; a vector table and a few
//               directed sequences pin down the documented corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        tick = 1'b0;
  logic        emp = 1'b1;
  logic        thr = 1'b0;
  logic [15:0] data = 16'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl_if #(.DATA_WIDTH(16), .CNT_WIDTH(16)) bus0 ();
  fifo_drain_ctrl_if #(.DATA_WIDTH(16), .CNT_WIDTH(2))  bus1 ();

  assign bus0.enable         = en;
  assign bus0.sample_tick    = tick;
  assign bus0.fifo_empty     = emp;
  assign bus0.fifo_threshold = thr;
  assign bus0.fifo_data      = data;
  assign bus1.enable         = en;
  assign bus1.sample_tick    = tick;
  assign bus1.fifo_empty     = emp;
  assign bus1.fifo_threshold = thr;
  assign bus1.fifo_data      = data;

  fifo_drain_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(16), .MUTE_ON_UNDERRUN(1'b1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  fifo_drain_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(2), .MUTE_ON_UNDERRUN(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // --------------------------------------------------------------------------
  // Reference model: a coarse mode (idle / prefill / run) plus the edge index
  // at which the current fetch was launched. The sample is taken two edges
  // after the launching tick; any tick in that window is an overrun.
  // --------------------------------------------------------------------------
  localparam int M_IDLE = 0;
  localparam int M_PRE  = 1;
  localparam int M_RUN  = 2;

  int edge_no = 0;
  int m_mode  [2];
  int m_fetch [2];
  int m_out   [2];
  int m_cnt   [2];
  bit m_ovr   [2];
  bit m_rd    [2];
  bit m_vld   [2];

  function automatic int cnt_max(input int k);
    return (k == 0) ? 65535 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k]  = M_IDLE;
      m_fetch[k] = -1;
      m_out[k]   = 0;
      m_cnt[k]   = 0;
      m_ovr[k]   = 1'b0;
      m_rd[k]    = 1'b0;
      m_vld[k]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_rd[k]  = 1'b0;
      m_vld[k] = 1'b0;
      if (!en) begin
        m_mode[k]  = M_IDLE;
        m_fetch[k] = -1;
        m_ovr[k]   = 1'b0;
      end else if (m_fetch[k] >= 0) begin
        if (tick) m_ovr[k] = 1'b1;
        if (edge_no - m_fetch[k] == 2) begin
          m_out[k]   = int'(data);
          m_vld[k]   = 1'b1;
          m_fetch[k] = -1;
        end
      end else if (m_mode[k] == M_IDLE) begin
        m_mode[k] = M_PRE;
      end else if (m_mode[k] == M_PRE) begin
        if (tick) begin
          m_out[k] = 0;
          m_vld[k] = 1'b1;
        end
        if (thr) m_mode[k] = M_RUN;
      end else if (tick) begin
        if (!emp) begin
          m_fetch[k] = edge_no;
          m_rd[k]    = 1'b1;
        end else begin
          m_vld[k] = 1'b1;
          if (k == 0) m_out[k] = 0;
          if (m_cnt[k] < cnt_max(k)) m_cnt[k] = m_cnt[k] + 1;
          m_mode[k] = M_PRE;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    chk("m0_rd",  {31'd0, bus0.fifo_rd},      {31'd0, m_rd[0]});
    chk("m0_vld", {31'd0, bus0.sample_valid}, {31'd0, m_vld[0]});
    chk("m0_out", {16'd0, bus0.sample_out},   m_out[0]);
    chk("m0_cnt", {16'd0, bus0.underrun_cnt}, m_cnt[0]);
    chk("m0_ovr", {31'd0, bus0.tick_overrun}, {31'd0, m_ovr[0]});
    chk("m0_run", {31'd0, bus0.running},      {31'd0, m_mode[0] == M_RUN});
    chk("m1_rd",  {31'd0, bus1.fifo_rd},      {31'd0, m_rd[1]});
    chk("m1_vld", {31'd0, bus1.sample_valid}, {31'd0, m_vld[1]});
    chk("m1_out", {16'd0, bus1.sample_out},   m_out[1]);
    chk("m1_cnt", {30'd0, bus1.underrun_cnt}, m_cnt[1]);
    chk("m1_ovr", {31'd0, bus1.tick_overrun}, {31'd0, m_ovr[1]});
    chk("m1_run", {31'd0, bus1.running},      {31'd0, m_mode[1] == M_RUN});
  endtask

  // One clock: inputs {en,tick,empty,threshold} applied before the edge,
  // outputs checked against the model on the following falling edge.
  task automatic cyc(input logic [3:0] in, input logic [15:0] d);
    {en, tick, emp, thr} = in;
    data = d;
    @(posedge clk);
    edge_no++;
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  // --------------------------------------------------------------------------
  // Vector table: in = {en,tick,empty,thr}, fl = {rd,valid,running,overrun}
  // out/cnt are dut0, out2 is dut1 sample_out (dut1 count equals cnt here).
  // --------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  in;
    logic [15:0] d;
    logic [3:0]  fl;
    logic [15:0] out;
    logic [15:0] out2;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] in, input logic [15:0] d, input logic [3:0] fl,
                              input logic [15:0] out, input logic [15:0] out2, input logic [15:0] cnt);
    vec_t v;
    v.in = in; v.d = d; v.fl = fl; v.out = out; v.out2 = out2; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl [21];

  initial begin
    int rdn;

    tbl[0]  = mk(4'b1110, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'd0); // idle->prefill, tick ignored
    tbl[1]  = mk(4'b1100, 16'h0000, 4'b0100, 16'h0000, 16'h0000, 16'd0); // prefill tick 1
    tbl[2]  = mk(4'b1000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'd0);
    tbl[3]  = mk(4'b1000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'd0);
    tbl[4]  = mk(4'b1100, 16'h0000, 4'b0100, 16'h0000, 16'h0000, 16'd0); // prefill tick 2
    tbl[5]  = mk(4'b1000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'd0);
    tbl[6]  = mk(4'b1000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'd0);
    tbl[7]  = mk(4'b1101, 16'h0000, 4'b0110, 16'h0000, 16'h0000, 16'd0); // tick 3 + threshold
    tbl[8]  = mk(4'b1000, 16'h0000, 4'b0010, 16'h0000, 16'h0000, 16'd0);
    tbl[9]  = mk(4'b1100, 16'h0000, 4'b1010, 16'h0000, 16'h0000, 16'd0); // tick at N: rd in N+1
    tbl[10] = mk(4'b1000, 16'hDEAD, 4'b0010, 16'h0000, 16'h0000, 16'd0);
    tbl[11] = mk(4'b1000, 16'h1234, 4'b0110, 16'h1234, 16'h1234, 16'd0); // valid in N+3
    tbl[12] = mk(4'b1000, 16'h0000, 4'b0010, 16'h1234, 16'h1234, 16'd0);
    tbl[13] = mk(4'b1100, 16'h0000, 4'b1010, 16'h1234, 16'h1234, 16'd0);
    tbl[14] = mk(4'b1000, 16'h0000, 4'b0010, 16'h1234, 16'h1234, 16'd0);
    tbl[15] = mk(4'b1000, 16'h00FF, 4'b0110, 16'h00FF, 16'h00FF, 16'd0);
    tbl[16] = mk(4'b1000, 16'h0000, 4'b0010, 16'h00FF, 16'h00FF, 16'd0);
    tbl[17] = mk(4'b1110, 16'h0000, 4'b0100, 16'h0000, 16'h00FF, 16'd1); // underrun
    tbl[18] = mk(4'b1010, 16'h0000, 4'b0000, 16'h0000, 16'h00FF, 16'd1); // back in prefill
    tbl[19] = mk(4'b1011, 16'h0000, 4'b0010, 16'h0000, 16'h00FF, 16'd1);
    tbl[20] = mk(4'b0000, 16'h0000, 4'b0000, 16'h0000, 16'h00FF, 16'd1); // disable, count kept

    model_reset();

    // Reset and idle behaviour.
    repeat (2) @(negedge clk);
    chk("rst_rd",  {31'd0, bus0.fifo_rd},      32'd0);
    chk("rst_vld", {31'd0, bus0.sample_valid}, 32'd0);
    chk("rst_out", {16'd0, bus0.sample_out},   32'd0);
    chk("rst_cnt", {16'd0, bus0.underrun_cnt}, 32'd0);
    chk("rst_ovr", {31'd0, bus0.tick_overrun}, 32'd0);
    chk("rst_run", {31'd0, bus0.running},      32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0101, 16'hBEEF);
      chk("idle_rd",  {31'd0, bus0.fifo_rd},      32'd0);
      chk("idle_vld", {31'd0, bus0.sample_valid}, 32'd0);
      cyc(4'b0001, 16'hBEEF);
      cyc(4'b0001, 16'hBEEF);
    end

    // Table-driven prefill / steady state / underrun.
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].in, tbl[i].d);
      chk($sformatf("tbl%0d_rd", i),   {31'd0, bus0.fifo_rd},      {31'd0, tbl[i].fl[3]});
      chk($sformatf("tbl%0d_vld", i),  {31'd0, bus0.sample_valid}, {31'd0, tbl[i].fl[2]});
      chk($sformatf("tbl%0d_run", i),  {31'd0, bus0.running},      {31'd0, tbl[i].fl[1]});
      chk($sformatf("tbl%0d_ovr", i),  {31'd0, bus0.tick_overrun}, {31'd0, tbl[i].fl[0]});
      chk($sformatf("tbl%0d_out", i),  {16'd0, bus0.sample_out},   {16'd0, tbl[i].out});
      chk($sformatf("tbl%0d_cnt", i),  {16'd0, bus0.underrun_cnt}, {16'd0, tbl[i].cnt});
      chk($sformatf("tbl%0d_out2", i), {16'd0, bus1.sample_out},   {16'd0, tbl[i].out2});
      chk($sformatf("tbl%0d_cnt2", i), {30'd0, bus1.underrun_cnt}, {16'd0, tbl[i].cnt});
    end

    // Four more underruns: dut1's 2-bit counter must stick at 3.
    cyc(4'b1010, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1011, 16'h0);
      cyc(4'b1110, 16'h0);
      chk("sat_vld", {31'd0, bus0.sample_valid}, 32'd1);
      cyc(4'b1010, 16'h0);
      cyc(4'b1010, 16'h0);
    end
    chk("sat_cnt2", {30'd0, bus1.underrun_cnt}, 32'd3);
    chk("sat_cnt0", {16'd0, bus0.underrun_cnt}, 32'd5);

    // Tick one cycle after a RUN tick: overrun, single read.
    cyc(4'b1001, 16'hA5A5);
    rdn = 0;
    cyc(4'b1100, 16'hA5A5); rdn += int'(bus0.fifo_rd);
    cyc(4'b1100, 16'hA5A5); rdn += int'(bus0.fifo_rd);
    chk("ovr_set", {31'd0, bus0.tick_overrun}, 32'd1);
    cyc(4'b1000, 16'hA5A5); rdn += int'(bus0.fifo_rd);
    chk("ovr_vld", {31'd0, bus0.sample_valid}, 32'd1);
    cyc(4'b1000, 16'hA5A5); rdn += int'(bus0.fifo_rd);
    cyc(4'b1000, 16'hA5A5); rdn += int'(bus0.fifo_rd);
    chk("ovr_one_rd", rdn, 32'd1);
    chk("ovr_sticky", {31'd0, bus0.tick_overrun}, 32'd1);
    chk("ovr_out", {16'd0, bus0.sample_out}, 32'h0000A5A5);

    // Disable while in READ.
    cyc(4'b1100, 16'h1111);
    chk("dis_rd_pre", {31'd0, bus0.fifo_rd}, 32'd1);
    cyc(4'b0000, 16'h2222);
    chk("dis_rd",  {31'd0, bus0.fifo_rd},      32'd0);
    chk("dis_vld", {31'd0, bus0.sample_valid}, 32'd0);
    chk("dis_run", {31'd0, bus0.running},      32'd0);
    chk("dis_ovr", {31'd0, bus0.tick_overrun}, 32'd0);
    cyc(4'b0000, 16'h2222);
    chk("dis_vld2", {31'd0, bus0.sample_valid}, 32'd0);
    chk("dis_hold", {16'd0, bus0.sample_out},   32'h0000A5A5);

    // Asynchronous reset while in CAPTURE.
    cyc(4'b1000, 16'h0);
    cyc(4'b1001, 16'h0);
    cyc(4'b1100, 16'h3333);
    cyc(4'b1000, 16'h4444);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd",   {31'd0, bus0.fifo_rd},      32'd0);
    chk("arst_vld",  {31'd0, bus0.sample_valid}, 32'd0);
    chk("arst_out",  {16'd0, bus0.sample_out},   32'd0);
    chk("arst_cnt",  {16'd0, bus0.underrun_cnt}, 32'd0);
    chk("arst_ovr",  {31'd0, bus0.tick_overrun}, 32'd0);
    chk("arst_run",  {31'd0, bus0.running},      32'd0);
    chk("arst_out2", {16'd0, bus1.sample_out},   32'd0);
    chk("arst_cnt2", {30'd0, bus1.underrun_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b1000, 16'h5555);
    chk("arst_novld", {31'd0, bus0.sample_valid}, 32'd0);
    cyc(4'b1000, 16'h5555);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] in;
      in[3] = ($urandom_range(0, 59) != 0);
      in[2] = ($urandom_range(0, 3) == 0);
      in[1] = ($urandom_range(0, 2) == 0);
      in[0] = ($urandom_range(0, 1) == 0);
      cyc(in, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
